// File: rtl/chirp_pkg.sv
// Shared types for the chirp sweep controller: sweep modes, FSM states and the
// config word layout at the default widths.
package chirp_pkg;

  localparam int unsigned CHIRP_PHASE_W  = 48;
  localparam int unsigned CHIRP_RATE_W   = 32;
  localparam int unsigned CHIRP_STEP_W   = 16;
  localparam int unsigned CHIRP_PH_OUT_W = 16;

  typedef enum logic [1:0] {
    MODE_SINGLE   = 2'd0,
    MODE_REPEAT   = 2'd1,
    MODE_TRIANGLE = 2'd2,
    MODE_RSVD     = 2'd3
  } mode_t;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  // Config word at default widths; the top re-declares it locally so that
  // non-default parameterisations stay consistent.
  typedef struct packed {
    logic [CHIRP_PHASE_W-1:0] freq;
    logic [CHIRP_PHASE_W-1:0] delta;
    logic [CHIRP_RATE_W-1:0]  rate;
    logic [CHIRP_STEP_W-1:0]  steps;
    mode_t                    mode;
  } chirp_cfg_t;

endpackage

// File: rtl/chirp_phase_acc.sv
// Phase accumulator with synchronous clear and enable; exposes the MSBs.
module chirp_phase_acc #(
  parameter int unsigned PHASE_W  = 48,
  parameter int unsigned PH_OUT_W = 16
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                clr_i,
  input  logic                en_i,
  input  logic [PHASE_W-1:0]  inc_i,
  output logic [PH_OUT_W-1:0] phase_o
);

  logic [PHASE_W-1:0] acc_q, acc_d;

  // Clear wins over accumulate; sum wraps modulo 2^PHASE_W.
  always_comb begin
    acc_d = acc_q;
    if (clr_i) begin
      acc_d = '0;
    end else if (en_i) begin
      acc_d = acc_q + inc_i;
    end
  end

  // Accumulator state.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

  assign phase_o = acc_q[PHASE_W-1 -: PH_OUT_W];

endmodule

// File: rtl/chirp_sweep_ctrl.sv
// Chirp sweep controller: shadowed config, start-edge triggered stepped phase
// increment generator with single / repeat / triangle modes.
module chirp_sweep_ctrl
  import chirp_pkg::*;
#(
  parameter int unsigned PHASE_W  = CHIRP_PHASE_W,
  parameter int unsigned RATE_W   = CHIRP_RATE_W,
  parameter int unsigned STEP_W   = CHIRP_STEP_W,
  parameter int unsigned PH_OUT_W = CHIRP_PH_OUT_W
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                cfg_valid,
  output logic                cfg_ready,
  input  logic [PHASE_W-1:0]  cfg_freq,
  input  logic [PHASE_W-1:0]  cfg_delta,
  input  logic [RATE_W-1:0]   cfg_rate,
  input  logic [STEP_W-1:0]   cfg_steps,
  input  logic [1:0]          cfg_mode,
  input  logic                start,
  output logic [PHASE_W-1:0]  phase_inc_o,
  output logic [PH_OUT_W-1:0] phase_o,
  output logic                valid_o,
  output logic                busy_o,
  output logic                done_o
);

  typedef struct packed {
    logic [PHASE_W-1:0] freq;
    logic [PHASE_W-1:0] delta;
    logic [RATE_W-1:0]  rate;
    logic [STEP_W-1:0]  steps;
    mode_t              mode;
  } cfg_word_t;

  localparam logic [RATE_W-1:0] RateOne = RATE_W'(1);
  localparam logic [STEP_W-1:0] StepOne = STEP_W'(1);

  state_t             st_q, st_d;
  cfg_word_t          shadow_q, shadow_d;
  cfg_word_t          act_q, act_d;
  logic [PHASE_W-1:0] inc_q, inc_d;
  logic [RATE_W-1:0]  rate_cnt_q, rate_cnt_d;
  logic [STEP_W-1:0]  step_cnt_q, step_cnt_d;
  logic               dir_q, dir_d;   // 0 = up, 1 = down
  logic               done_q, done_d;
  logic               start_q;
  logic               start_edge;
  logic               step_evt;
  logic               acc_clr;
  logic               acc_en;

  assign start_edge = start & ~start_q;
  assign busy_o     = (st_q == ST_RUN);
  assign valid_o    = busy_o;
  assign cfg_ready  = ~busy_o;
  assign phase_inc_o = inc_q;
  assign done_o     = done_q;

  // Shadow capture: any accepted config word, even on a start-edge cycle.
  always_comb begin
    shadow_d = shadow_q;
    if (cfg_valid && cfg_ready) begin
      shadow_d = '{freq:  cfg_freq,
                   delta: cfg_delta,
                   rate:  cfg_rate,
                   steps: cfg_steps,
                   mode:  mode_t'(cfg_mode)};
    end
  end

  // Sweep FSM: launch from shadow, dwell counting, step / end-of-leg handling.
  always_comb begin
    st_d       = st_q;
    act_d      = act_q;
    inc_d      = inc_q;
    rate_cnt_d = rate_cnt_q;
    step_cnt_d = step_cnt_q;
    dir_d      = dir_q;
    done_d     = 1'b0;
    step_evt   = 1'b0;
    acc_clr    = 1'b0;
    acc_en     = 1'b0;
    case (st_q)
      ST_IDLE: begin
        acc_clr = 1'b1;
        if (start_edge) begin
          st_d       = ST_RUN;
          act_d      = shadow_q;
          inc_d      = shadow_q.freq;
          rate_cnt_d = '0;
          step_cnt_d = '0;
          dir_d      = 1'b0;
        end
      end
      ST_RUN: begin
        acc_en = 1'b1;
        if (!start) begin
          // Abort outranks any step event and produces no done pulse.
          st_d       = ST_IDLE;
          inc_d      = '0;
          rate_cnt_d = '0;
          step_cnt_d = '0;
          dir_d      = 1'b0;
          acc_clr    = 1'b1;
        end else begin
          step_evt   = (rate_cnt_q == act_q.rate);
          rate_cnt_d = step_evt ? '0 : rate_cnt_q + RateOne;
          if (step_evt && (act_q.steps != '0)) begin
            if (step_cnt_q == act_q.steps - StepOne) begin
              done_d     = 1'b1;
              step_cnt_d = '0;
              case (act_q.mode)
                MODE_REPEAT:   inc_d = act_q.freq;
                MODE_TRIANGLE: dir_d = ~dir_q;
                default: begin
                  st_d       = ST_IDLE;
                  inc_d      = '0;
                  rate_cnt_d = '0;
                  dir_d      = 1'b0;
                  acc_clr    = 1'b1;
                end
              endcase
            end else begin
              inc_d      = dir_q ? inc_q - act_q.delta : inc_q + act_q.delta;
              step_cnt_d = step_cnt_q + StepOne;
            end
          end
        end
      end
      default: st_d = ST_IDLE;
    endcase
  end

  // Controller state registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st_q       <= ST_IDLE;
      shadow_q   <= '0;
      act_q      <= '0;
      inc_q      <= '0;
      rate_cnt_q <= '0;
      step_cnt_q <= '0;
      dir_q      <= 1'b0;
      done_q     <= 1'b0;
      start_q    <= 1'b0;
    end else begin
      st_q       <= st_d;
      shadow_q   <= shadow_d;
      act_q      <= act_d;
      inc_q      <= inc_d;
      rate_cnt_q <= rate_cnt_d;
      step_cnt_q <= step_cnt_d;
      dir_q      <= dir_d;
      done_q     <= done_d;
      start_q    <= start;
    end
  end

  chirp_phase_acc #(
    .PHASE_W  (PHASE_W),
    .PH_OUT_W (PH_OUT_W)
  ) u_phase_acc (
    .clk_i   (clk),
    .rst_i   (rst),
    .clr_i   (acc_clr),
    .en_i    (acc_en),
    .inc_i   (inc_q),
    .phase_o (phase_o)
  );

endmodule

// File: tb/tb_chirp_sweep_ctrl.sv
// Self-checking bench for chirp_sweep_ctrl: per-cycle expected output words
// are queued as stimulus is set up and compared as the DUT advances.
module tb_chirp_sweep_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        cfg_valid;
  logic        cfg_ready;
  logic [47:0] cfg_freq;
  logic [47:0] cfg_delta;
  logic [31:0] cfg_rate;
  logic [15:0] cfg_steps;
  logic [1:0]  cfg_mode;
  logic        start;
  logic [47:0] phase_inc_o;
  logic [15:0] phase_o;
  logic        valid_o;
  logic        busy_o;
  logic        done_o;

  int checks   = 0;
  int failures = 0;

  typedef struct packed {
    logic [47:0] inc;
    logic [15:0] ph;
    logic        valid;
    logic        busy;
    logic        done;
    logic        ready;
  } obs_t;

  obs_t exp_q[$];

  chirp_sweep_ctrl #(
    .PHASE_W  (48),
    .RATE_W   (32),
    .STEP_W   (16),
    .PH_OUT_W (16)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .cfg_valid   (cfg_valid),
    .cfg_ready   (cfg_ready),
    .cfg_freq    (cfg_freq),
    .cfg_delta   (cfg_delta),
    .cfg_rate    (cfg_rate),
    .cfg_steps   (cfg_steps),
    .cfg_mode    (cfg_mode),
    .start       (start),
    .phase_inc_o (phase_inc_o),
    .phase_o     (phase_o),
    .valid_o     (valid_o),
    .busy_o      (busy_o),
    .done_o      (done_o)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic obs_t sample();
    return obs_t'{phase_inc_o, phase_o, valid_o, busy_o, done_o, cfg_ready};
  endfunction

  function automatic void push(logic [47:0] inc, logic [15:0] ph, logic v, logic b,
                               logic d, logic r);
    exp_q.push_back(obs_t'{inc, ph, v, b, d, r});
  endfunction

  task automatic load_cfg(logic [47:0] f, logic [47:0] dl, logic [31:0] rt,
                          logic [15:0] st, logic [1:0] md);
    cfg_freq  = f;
    cfg_delta = dl;
    cfg_rate  = rt;
    cfg_steps = st;
    cfg_mode  = md;
    cfg_valid = 1'b1;
    tick();
    cfg_valid = 1'b0;
  endtask

  task automatic test_reset();
    obs_t o;
    o = sample();
    checks++;
    if (o !== obs_t'{48'd0, 16'd0, 1'b0, 1'b0, 1'b0, 1'b1}) begin
      failures++;
      $display("FAIL reset got=%h want ready-only", o);
    end
  endtask

  task automatic test_single();
    obs_t e, o;
    logic [47:0] acc;
    logic [47:0] inc;
    int n;
    load_cfg(48'd1000, 48'd10, 32'd2, 16'd4, 2'd0);
    acc = '0;
    for (int k = 0; k < 12; k++) begin
      inc = 48'(1000 + 10 * (k / 3));
      push(inc, acc[47:32], 1'b1, 1'b1, 1'b0, 1'b0);
      acc = acc + inc;
    end
    push(48'd0, 16'd0, 1'b0, 1'b0, 1'b1, 1'b1);
    push(48'd0, 16'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    start = 1'b1;
    n = 0;
    while (exp_q.size() > 0) begin
      tick();
      n++;
      e = exp_q.pop_front();
      o = sample();
      checks++;
      if (o !== e) begin
        failures++;
        $display("FAIL single cycle=%0d got=%h want=%h", n, o, e);
      end
    end
    start = 1'b0;
    tick();
  endtask

  task automatic test_repeat();
    obs_t e, o;
    logic [47:0] acc;
    logic [47:0] inc;
    int n;
    load_cfg(48'd1000, 48'd10, 32'd2, 16'd4, 2'd1);
    acc = '0;
    for (int k = 0; k < 30; k++) begin
      inc = 48'(1000 + 10 * ((k % 12) / 3));
      push(inc, acc[47:32], 1'b1, 1'b1, (k > 0) && (k % 12 == 0), 1'b0);
      acc = acc + inc;
    end
    push(48'd0, 16'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    start = 1'b1;
    n = 0;
    while (exp_q.size() > 0) begin
      if (exp_q.size() == 1) start = 1'b0;
      tick();
      n++;
      e = exp_q.pop_front();
      o = sample();
      checks++;
      if (o !== e) begin
        failures++;
        $display("FAIL repeat cycle=%0d got=%h want=%h", n, o, e);
      end
    end
  endtask

  task automatic test_triangle();
    obs_t e, o;
    int tri_inc[9];
    int n;
    tri_inc = '{0, 1, 2, 2, 1, 0, 0, 1, 2};
    load_cfg(48'd0, 48'd1, 32'd0, 16'd3, 2'd2);
    for (int k = 0; k < 9; k++) begin
      push(48'(tri_inc[k]), 16'd0, 1'b1, 1'b1, (k == 3) || (k == 6), 1'b0);
    end
    // Cycle 9 ends a leg but the abort on that edge suppresses done_o.
    push(48'd0, 16'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    start = 1'b1;
    n = 0;
    while (exp_q.size() > 0) begin
      if (exp_q.size() == 1) start = 1'b0;
      tick();
      n++;
      e = exp_q.pop_front();
      o = sample();
      checks++;
      if (o !== e) begin
        failures++;
        $display("FAIL triangle cycle=%0d got=%h want=%h", n, o, e);
      end
    end
  endtask

  task automatic test_wrap();
    obs_t e, o;
    int n;
    load_cfg(48'hFFFF_FFFF_FFFF, 48'd2, 32'd0, 16'd2, 2'd0);
    push(48'hFFFF_FFFF_FFFF, 16'd0, 1'b1, 1'b1, 1'b0, 1'b0);
    push(48'd1, 16'hFFFF, 1'b1, 1'b1, 1'b0, 1'b0);
    push(48'd0, 16'd0, 1'b0, 1'b0, 1'b1, 1'b1);
    push(48'd0, 16'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    start = 1'b1;
    n = 0;
    while (exp_q.size() > 0) begin
      tick();
      n++;
      e = exp_q.pop_front();
      o = sample();
      checks++;
      if (o !== e) begin
        failures++;
        $display("FAIL wrap cycle=%0d got=%h want=%h", n, o, e);
      end
    end
    start = 1'b0;
    tick();
  endtask

  task automatic test_const_tone();
    obs_t e, o;
    logic [47:0] acc;
    int n;
    load_cfg(48'h1000_0000_0000, 48'd5, 32'd0, 16'd0, 2'd1);
    acc = '0;
    for (int k = 0; k < 6; k++) begin
      push(48'h1000_0000_0000, acc[47:32], 1'b1, 1'b1, 1'b0, 1'b0);
      acc = acc + 48'h1000_0000_0000;
    end
    push(48'd0, 16'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    start = 1'b1;
    n = 0;
    while (exp_q.size() > 0) begin
      if (exp_q.size() == 1) start = 1'b0;
      tick();
      n++;
      e = exp_q.pop_front();
      o = sample();
      checks++;
      if (o !== e) begin
        failures++;
        $display("FAIL const_tone cycle=%0d got=%h want=%h", n, o, e);
      end
    end
  endtask

  task automatic test_abort();
    obs_t e, o;
    logic [47:0] acc;
    logic [47:0] inc;
    int n;
    load_cfg(48'd1000, 48'd10, 32'd2, 16'd4, 2'd0);
    acc = '0;
    for (int k = 0; k < 5; k++) begin
      inc = 48'(1000 + 10 * (k / 3));
      push(inc, acc[47:32], 1'b1, 1'b1, 1'b0, 1'b0);
      acc = acc + inc;
    end
    push(48'd0, 16'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    push(48'd0, 16'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    start = 1'b1;
    n = 0;
    while (exp_q.size() > 0) begin
      if (exp_q.size() == 2) start = 1'b0;
      tick();
      n++;
      e = exp_q.pop_front();
      o = sample();
      checks++;
      if (o !== e) begin
        failures++;
        $display("FAIL abort cycle=%0d got=%h want=%h", n, o, e);
      end
    end
  endtask

  task automatic test_handshake();
    load_cfg(48'd1000, 48'd10, 32'd2, 16'd4, 2'd0);
    start = 1'b1;
    tick();
    cfg_freq  = 48'd5000;
    cfg_valid = 1'b1;
    checks++;
    if (cfg_ready !== 1'b0) begin
      failures++;
      $display("FAIL busy_ready got=%b want=0", cfg_ready);
    end
    tick();
    tick();
    cfg_valid = 1'b0;
    start = 1'b0;
    tick();
    start = 1'b1;
    tick();
    checks++;
    if (phase_inc_o !== 48'd1000) begin
      failures++;
      $display("FAIL shadow_hold got=%0d want=1000", phase_inc_o);
    end
    start = 1'b0;
    tick();
    // Config and start edge on the same cycle.
    cfg_freq  = 48'd7000;
    cfg_valid = 1'b1;
    start     = 1'b1;
    tick();
    cfg_valid = 1'b0;
    checks++;
    if (phase_inc_o !== 48'd1000) begin
      failures++;
      $display("FAIL same_cycle_old got=%0d want=1000", phase_inc_o);
    end
    start = 1'b0;
    tick();
    start = 1'b1;
    tick();
    checks++;
    if (phase_inc_o !== 48'd7000) begin
      failures++;
      $display("FAIL same_cycle_new got=%0d want=7000", phase_inc_o);
    end
    start = 1'b0;
    tick();
  endtask

  task automatic test_async_reset();
    obs_t o;
    load_cfg(48'd1000, 48'd10, 32'd2, 16'd4, 2'd1);
    start = 1'b1;
    repeat (4) tick();
    #2;
    rst = 1'b1;
    #1;
    o = sample();
    checks++;
    if (o !== obs_t'{48'd0, 16'd0, 1'b0, 1'b0, 1'b0, 1'b1}) begin
      failures++;
      $display("FAIL async_reset got=%h want ready-only", o);
    end
    start = 1'b0;
    #1;
    rst = 1'b0;
    tick();
    checks++;
    if (cfg_ready !== 1'b1) begin
      failures++;
      $display("FAIL post_reset_ready got=%b want=1", cfg_ready);
    end
    // Shadow cleared by reset: a fresh start gives a zero constant tone.
    start = 1'b1;
    tick();
    tick();
    o = sample();
    checks++;
    if (o !== obs_t'{48'd0, 16'd0, 1'b1, 1'b1, 1'b0, 1'b0}) begin
      failures++;
      $display("FAIL post_reset_shadow got=%h want=%h", o,
               obs_t'{48'd0, 16'd0, 1'b1, 1'b1, 1'b0, 1'b0});
    end
    start = 1'b0;
    tick();
  endtask

  initial begin
    rst       = 1'b1;
    cfg_valid = 1'b0;
    cfg_freq  = '0;
    cfg_delta = '0;
    cfg_rate  = '0;
    cfg_steps = '0;
    cfg_mode  = '0;
    start     = 1'b0;
    #2;
    test_reset();
    #10;
    rst = 1'b0;
    tick();
    test_single();
    test_repeat();
    test_triangle();
    test_wrap();
    test_const_tone();
    test_abort();
    test_handshake();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/chirp_sweep_ctrl.md
Name: chirp_sweep_ctrl

Overview:
Parametrised chirp (linear FM sweep) controller in a single clock domain. It accepts sweep parameters over a valid/ready handshake into shadow registers and generates a stepped phase increment and a running phase word on a start edge. Three sweep modes are supported: single, repeat and triangle, each with a programmable step count. It sits ahead of the DDS/NCO (phase-to-amplitude) stage and replaces the hard-wired single-ramp chirp control.

Parameters:
PHASE_W, 48, width of phase increment, delta and phase accumulator
RATE_W, 32, width of dwell counter (cycles per step minus one)
STEP_W, 16, width of step counter / step count
PH_OUT_W, 16, width of truncated phase output (MSBs of accumulator), must be <= PHASE_W

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-high reset
cfg_valid  in  1  config word valid
cfg_ready  out  1  config accepted when high with cfg_valid; equals !busy_o
cfg_freq  in  PHASE_W  start phase increment (unsigned)
cfg_delta  in  PHASE_W  per-step increment change, two's complement
cfg_rate  in  RATE_W  dwell: increment held cfg_rate+1 cycles per step
cfg_steps  in  STEP_W  step events per sweep leg; 0 = constant tone
cfg_mode  in  2  0 single, 1 repeat, 2 triangle, 3 treated as single
start  in  1  level, synchronous to clk; rising edge starts, low aborts
phase_inc_o  out  PHASE_W  current phase increment
phase_o  out  PH_OUT_W  accumulator[PHASE_W-1 -: PH_OUT_W]
valid_o  out  1  high while sweeping
busy_o  out  1  high in RUN
done_o  out  1  one-cycle pulse at each end-of-leg event

Behaviour:
- Reset (async): all outputs, shadow regs, counters, start_d, direction = 0; state IDLE; cfg_ready then 1.
- Handshake: transfer when cfg_valid & cfg_ready; all cfg fields captured into shadow on that edge. No transfer while busy (cfg_ready=0).
- Start edge = start & !start_d (start_d registered each cycle). Only acted on in IDLE.
- Config and start edge on the same cycle: sweep uses the OLD shadow; the new config is still captured.
- FSM IDLE -> RUN on start edge. On that edge: inc<=shadow freq, acc<=0, rate_cnt<=0, step_cnt<=0, dir<=up, active copy of delta/rate/steps/mode taken from shadow. Next cycle: valid_o=busy_o=1, phase_inc_o=freq, phase_o=0.
- RUN each edge: acc<=acc+inc (mod 2^PHASE_W). If rate_cnt==rate: rate_cnt<=0 and a step event occurs; else rate_cnt++.
- Step event, normal: inc<=inc+delta (dir up) or inc-delta (dir down), mod 2^PHASE_W, no saturation; step_cnt++.
- Step event with step_cnt==steps-1 (steps!=0) = end-of-leg; done_o pulses next cycle; step_cnt<=0; no normal add. Single: -> IDLE, outputs zeroed. Repeat: inc<=freq, acc continues. Triangle: inc held, dir toggled.
- steps==0: no step events alter inc; constant tone; no done.
- RUN -> IDLE when start==0 (abort), taking priority over any step event; no done_o; next cycle valid_o=busy_o=0, phase_inc_o=0, phase_o=0.
- In IDLE, phase_inc_o, phase_o and valid_o are all 0.

Decomposition:
- Package chirp_pkg: typedef enum logic [1:0] mode_t {MODE_SINGLE, MODE_REPEAT, MODE_TRIANGLE, MODE_RSVD}; typedef enum {ST_IDLE, ST_RUN} state_t; a packed struct for the config word (freq, delta, rate, steps, mode).
- One sub-module, chirp_phase_acc: PHASE_W accumulator with clear and enable, output truncation to PH_OUT_W.

Test Plan:
1. Single: freq=1000, delta=10, rate=2, steps=4, mode 0 -> phase_inc_o 1000,1010,1020,1030, each for 3 cycles; 12 valid cycles; done_o pulses once as valid_o falls; busy_o then 0.
2. Repeat: same config, mode 1 -> 1000..1030 sequence repeats; done_o pulses every 12 cycles; valid_o stays high until start is driven low.
3. Triangle: freq=0, delta=1, rate=0, steps=3, mode 2 -> phase_inc_o per cycle 0,1,2,2,1,0,0,1,2...; done_o on each hold cycle.
4. Wrap: freq=2^48-1, delta=2, rate=0, steps=2, mode 0 -> phase_inc_o 2^48-1 then 1; phase_o follows the modulo sum.
5. Abort/handshake: drop start at cycle 5 of test 1 -> next cycle all outputs 0 with no done_o. cfg_valid while busy -> cfg_ready=0 and shadow unchanged. cfg and start edge on the same cycle -> old freq used, new freq used on next start.
6. Async reset asserted mid-RUN without a clock edge -> outputs 0 immediately; after release cfg_ready=1 and shadow=0.
